// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared defaults and bus-mode decode for the ram block (option: RAM_RST_CLEAR_EN)
package ram_pkg;

  localparam int ADR_SIZE = 4;
  localparam int DTA_SIZE = 8;
  localparam int DEPTH    = 2 ** ADR_SIZE;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WRITE    = 2'b01,
    READ     = 2'b10,
    CONFLICT = 2'b11
  } mode_e;

  // Both enables high is a conflict, and it is handled exactly like idle.
  function automatic mode_e decode_mode(input logic wr_en, input logic read_en);
    mode_e m;
    case ({read_en, wr_en})
      2'b01:   m = WRITE;
      2'b10:   m = READ;
      2'b11:   m = CONFLICT;
      default: m = IDLE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ram_array.sv
// rtl/ram_array.sv - word storage with synchronous write/clear and combinational read (option: RAM_RST_CLEAR_EN)
module ram_array
  import ram_pkg::*;
#(
  parameter int ADR_W = ADR_SIZE,
  parameter int DTA_W = DTA_SIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [ADR_W-1:0] addr,
  input  logic [DTA_W-1:0] wdata,
  output logic [DTA_W-1:0] rdata
);

  localparam int WORDS = 2 ** ADR_W;

  logic [DTA_W-1:0] mem [WORDS];

`ifdef RAM_RST_CLEAR_EN
  // Reset wipes every word; otherwise store on a qualified write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end
`else
  // Reset only blocks the write; contents survive reset untouched.
  always_ff @(posedge clk) begin
    if (rst_n && we) begin
      mem[addr] <= wdata;
    end
  end
`endif

  assign rdata = mem[addr];

endmodule

// File: rtl/ram.sv
// rtl/ram.sv - single-port ram top: mode decode and tri-state data bus (option: RAM_RST_CLEAR_EN)
module ram
  import ram_pkg::*;
#(
  parameter int Adr_size = ADR_SIZE,
  parameter int Dta_size = DTA_SIZE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [Adr_size-1:0] adress,
  inout  wire  [Dta_size-1:0] data,
  input  logic                wr_en,
  input  logic                read_en
);

  mode_e               mode;
  logic                array_we;
  logic [Dta_size-1:0] rd_word;

  // Collapse the two enables into one bus mode; reset does not affect it.
  always_comb begin
    mode     = decode_mode(wr_en, read_en);
    array_we = (mode == WRITE);
  end

  // The ram owns the bus only in read mode; everywhere else it floats.
  assign data = (mode == READ) ? rd_word : {Dta_size{1'bz}};

  ram_array #(
    .ADR_W (Adr_size),
    .DTA_W (Dta_size)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (array_we),
    .addr  (adress),
    .wdata (data),
    .rdata (rd_word)
  );

endmodule

// File: tb/tb_ram.sv
// tb/tb_ram.sv - self-checking bench for ram, reference memory model plus directed vectors (option: RAM_RST_CLEAR_EN)
module tb_ram;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] adress = '0;
  logic       wr_en = 1'b0;
  logic       read_en = 1'b0;
  logic       tb_drive = 1'b0;
  logic [7:0] tb_data = '0;
  tri1  [7:0] data_bus;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: plain array plus a known-contents flag per word
  logic [7:0] model_mem [16];
  logic       model_vld [16];

  assign data_bus = tb_drive ? tb_data : 8'bzzzzzzzz;

  always #5 clk = ~clk;

  ram dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .adress  (adress),
    .data    (data_bus),
    .wr_en   (wr_en),
    .read_en (read_en)
  );

  initial begin
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = 8'h00;
      model_vld[i] = 1'b0;
    end
  end

  // model update: write only out of reset with exactly one enable (write)
  always @(posedge clk) begin
    if (!rst_n) begin
`ifdef RAM_RST_CLEAR_EN
      for (int i = 0; i < 16; i++) begin
        model_mem[i] <= 8'h00;
        model_vld[i] <= 1'b1;
      end
`endif
    end else if (wr_en && !read_en) begin
      model_mem[adress] <= data_bus;
      model_vld[adress] <= 1'b1;
    end
  end

  // per-cycle compare: read mode shows memory, otherwise whoever else drives (or pull-up)
  always @(negedge clk) begin
    logic [7:0] exp;
    logic       known;
    known = 1'b1;
    if (read_en && !wr_en) begin
      exp   = model_mem[adress];
      known = model_vld[adress];
    end else if (tb_drive) begin
      exp = tb_data;
    end else begin
      exp = 8'hFF;
    end
    if (known) begin
      n_checks++;
      if (data_bus !== exp) begin
        n_fail++;
        $display("FAIL cycle_bus adr=%0d wr=%0b rd=%0b rst_n=%0b got=%h want=%h",
                 adress, wr_en, read_en, rst_n, data_bus, exp);
      end
    end
  end

  task automatic cyc(input logic r, input logic w, input logic rd, input logic [3:0] a,
                     input logic drv, input logic [7:0] v);
    @(negedge clk);
    #1;
    rst_n    = r;
    wr_en    = w;
    read_en  = rd;
    adress   = a;
    tb_drive = drv;
    tb_data  = v;
    #2;
  endtask

  task automatic expect_now(input string name, input logic [7:0] want);
    n_checks++;
    if (data_bus !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, data_bus, want);
    end
  endtask

  initial begin
    logic [7:0] after_rst1;
    logic [7:0] after_rst15;
    logic [7:0] pat;
`ifdef RAM_RST_CLEAR_EN
    after_rst1  = 8'h00;
    after_rst15 = 8'h00;
`else
    after_rst1  = 8'b00010000;
    after_rst15 = 8'h5A;
`endif

    cyc(0, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 8'h00);
    expect_now("reset_idle_bus", 8'hFF);

    cyc(1, 1, 0, 4'h1, 1, 8'b00010000);
    cyc(1, 0, 1, 4'h1, 0, 8'h00);
    expect_now("write_then_read_a1", 8'b00010000);

    cyc(1, 0, 0, 4'h1, 0, 8'h00);
    expect_now("idle_not_driven", 8'hFF);
    cyc(1, 0, 1, 4'h1, 0, 8'h00);
    expect_now("read_after_idle_a1", 8'b00010000);

    cyc(1, 1, 1, 4'h1, 1, 8'hAA);
    cyc(1, 1, 1, 4'h1, 0, 8'h00);
    expect_now("conflict_not_driven", 8'hFF);
    cyc(1, 0, 1, 4'h1, 0, 8'h00);
    expect_now("read_after_conflict_a1", 8'b00010000);

    cyc(1, 1, 0, 4'hF, 1, 8'h5A);
    cyc(1, 1, 0, 4'h0, 1, 8'hA5);
    cyc(1, 0, 1, 4'hF, 0, 8'h00);
    expect_now("read_a15", 8'h5A);
    adress = 4'h0;
    #1;
    expect_now("comb_addr_change_a0", 8'hA5);
    adress = 4'h1;
    #1;
    expect_now("comb_addr_change_a1", 8'b00010000);

    cyc(1, 1, 0, 4'h7, 1, 8'h3C);
    for (int k = 0; k < 5; k++) cyc(1, 0, 0, 4'h7, 0, 8'h00);
    cyc(1, 0, 1, 4'h7, 0, 8'h00);
    expect_now("persist_a7", 8'h3C);

    cyc(0, 1, 0, 4'h1, 1, 8'h77);
    cyc(0, 0, 1, 4'h1, 0, 8'h00);
    expect_now("read_during_reset_a1", after_rst1);
    cyc(1, 0, 1, 4'h1, 0, 8'h00);
    expect_now("read_after_reset_a1", after_rst1);
    cyc(1, 0, 1, 4'hF, 0, 8'h00);
    expect_now("read_after_reset_a15", after_rst15);

    for (int a = 0; a < 16; a++) begin
      pat = {a[3:0], ~a[3:0]};
      cyc(1, 1, 0, a[3:0], 1, pat);
    end
    for (int a = 0; a < 16; a++) begin
      pat = {a[3:0], ~a[3:0]};
      cyc(1, 0, 1, a[3:0], 0, 8'h00);
      expect_now("sweep_readback", pat);
    end

    cyc(1, 0, 0, 4'h0, 0, 8'h00);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
